ac97_cmd_sched: RTL

//  Slot-1/slot-2 command scheduler for the AC97 link. Replaces fixed codec config with a sequenced init plus

---
 rtl/ac97_cmd_sched_pkg.sv | 59 +++++
 rtl/ac97_rr_arb.sv | 43 ++++
 rtl/ac97_cmd_sched.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ac97_cmd_sched_pkg.sv
// Shared definitions for the AC97 slot-1/slot-2 command scheduler:
// slot layout, codec register indices, scheduler states and the init table.
package ac97_cmd_sched_pkg;

  localparam int SLOT_W = 20;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 16;

  localparam logic [6:0] REG_RESET      = 7'h00;
  localparam logic [6:0] REG_MASTER_VOL = 7'h02;
  localparam logic [6:0] REG_PCM_VOL    = 7'h18;
  localparam logic [6:0] REG_PWR        = 7'h26;

  localparam logic CMD_RD = 1'b1;
  localparam logic CMD_WR = 1'b0;

  // init_idx value reached once the last init entry has been issued
  localparam logic [1:0] INIT_END = 2'd3;

  typedef enum logic [1:0] {
    ST_WAIT_RDY = 2'd0,
    ST_INIT     = 2'd1,
    ST_IDLE     = 2'd2,
    ST_RD_WAIT  = 2'd3
  } state_t;

  typedef struct packed {
    logic                rd;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
  } cmd_t;

  function automatic cmd_t init_entry(input logic [1:0] idx);
    cmd_t c;
    case (idx)
      2'd0:    c = '{rd: CMD_WR, addr: REG_RESET,      data: 16'h0000};
      2'd1:    c = '{rd: CMD_WR, addr: REG_MASTER_VOL, data: 16'h0000};
      2'd2:    c = '{rd: CMD_WR, addr: REG_PCM_VOL,    data: 16'h0808};
      default: c = '{rd: CMD_WR, addr: REG_RESET,      data: 16'h0000};
    endcase
    return c;
  endfunction

  function automatic logic [SLOT_W-1:0] slot1_of(input cmd_t c);
    return {c.rd, c.addr, 12'h000};
  endfunction

  // reads carry no data word, so slot 2 stays zero for them
  function automatic logic [SLOT_W-1:0] slot2_of(input cmd_t c);
    logic [SLOT_W-1:0] s;
    if (c.rd) begin
      s = 20'h00000;
    end else begin
      s = {c.data, 4'h0};
    end
    return s;
  endfunction

endpackage

// File: rtl/ac97_rr_arb.sv
// Round-robin requester picker: first asserted request at or after ptr,
// wrapping modulo NREQ; returns a one-hot grant and its index.
module ac97_rr_arb
  import ac97_cmd_sched_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  int               cand_s;
  logic [IDX_W-1:0] cand_idx_s;

  // scan requesters in rotated order and keep the first hit
  always_comb begin
    grant      = '0;
    grant_idx  = '0;
    grant_any  = 1'b0;
    cand_s     = 0;
    cand_idx_s = '0;
    for (int off = 0; off < NREQ; off++) begin
      if (int'(ptr) + off >= NREQ) begin
        cand_s = int'(ptr) + off - NREQ;
      end else begin
        cand_s = int'(ptr) + off;
      end
      cand_idx_s = IDX_W'(cand_s);
      if (!grant_any && req[cand_idx_s]) begin
        grant_any         = 1'b1;
        grant[cand_idx_s] = 1'b1;
        grant_idx         = cand_idx_s;
      end else begin
        grant_any = grant_any;
      end
    end
  end

endmodule

// File: rtl/ac97_cmd_sched.sv
// AC97 command scheduler: replays the codec init list after codec ready, then
// arbitrates requesters for one register access per frame and routes read status back.
module ac97_cmd_sched
  import ac97_cmd_sched_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_FRAMES = 16
) (
  input  logic                 ac97_bitclk,
  input  logic                 rst,
  input  logic                 ac97_strobe,
  input  logic                 codec_ready,
  input  logic [19:0]          in_slot1,
  input  logic                 in_slot1_valid,
  input  logic [19:0]          in_slot2,
  input  logic                 in_slot2_valid,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_rd,
  input  logic [7*NREQ-1:0]    req_addr,
  input  logic [16*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ack,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [15:0]          rsp_data,
  output logic                 rsp_timeout,
  output logic                 init_done,
  output logic [19:0]          ac97_out_slot1,
  output logic                 ac97_out_slot1_valid,
  output logic [19:0]          ac97_out_slot2,
  output logic                 ac97_out_slot2_valid
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_FRAMES + 1);

  state_t            state_r, state_s;
  logic [IDX_W-1:0]  ptr_r, ptr_s;
  logic [1:0]        init_idx_r, init_idx_s;
  logic [IDX_W-1:0]  rd_idx_r, rd_idx_s;
  logic [6:0]        rd_addr_r, rd_addr_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [19:0]       slot1_r, slot1_s, slot2_r, slot2_s;
  logic              slot1_v_r, slot1_v_s, slot2_v_r, slot2_v_s;
  logic [NREQ-1:0]   ack_r, ack_s, rsp_v_r, rsp_v_s;
  logic [15:0]       rsp_data_r, rsp_data_s;
  logic              rsp_to_r, rsp_to_s;
  logic              init_done_r, init_done_s;

  logic              issue_en_s, grant_en_s, match_s;
  cmd_t              issue_cmd_s;
  logic [NREQ-1:0]   grant_s;
  logic [IDX_W-1:0]  gidx_s;
  logic              grant_any_s;
  logic [6:0]        addr_arr_s  [NREQ];
  logic [15:0]       wdata_arr_s [NREQ];
  logic              unused_bits_s;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr_s[i]  = req_addr[7*i +: 7];
    assign wdata_arr_s[i] = req_wdata[16*i +: 16];
  end

  assign unused_bits_s = ^{in_slot1[19], in_slot1[11:0], in_slot2[3:0]};
  assign match_s = in_slot1_valid & in_slot2_valid & (in_slot1[18:12] == rd_addr_r);

  ac97_rr_arb #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_r),
    .grant     (grant_s),
    .grant_idx (gidx_s),
    .grant_any (grant_any_s)
  );

  // next-state, slot and pulse decisions, evaluated only on the frame strobe
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    init_idx_s  = init_idx_r;
    rd_idx_s    = rd_idx_r;
    rd_addr_s   = rd_addr_r;
    cnt_s       = cnt_r;
    slot1_s     = slot1_r;
    slot1_v_s   = slot1_v_r;
    slot2_s     = slot2_r;
    slot2_v_s   = slot2_v_r;
    rsp_data_s  = rsp_data_r;
    init_done_s = init_done_r;
    ack_s       = '0;
    rsp_v_s     = '0;
    rsp_to_s    = 1'b0;
    issue_en_s  = 1'b0;
    grant_en_s  = 1'b0;
    issue_cmd_s = '0;
    if (ac97_strobe) begin
      slot1_s   = 20'h00000;
      slot1_v_s = 1'b0;
      slot2_s   = 20'h00000;
      slot2_v_s = 1'b0;
      if ((state_r != ST_WAIT_RDY) && !codec_ready) begin
        // codec dropped out: close any open read and rerun init on next ready
        if (state_r == ST_RD_WAIT) begin
          rsp_v_s[rd_idx_r] = 1'b1;
          rsp_data_s        = 16'hFFFF;
          rsp_to_s          = 1'b1;
        end else begin
          rsp_to_s = 1'b0;
        end
        state_s     = ST_WAIT_RDY;
        init_done_s = 1'b0;
        init_idx_s  = 2'd0;
        cnt_s       = '0;
      end else begin
        case (state_r)
          ST_WAIT_RDY: begin
            if (codec_ready) begin
              state_s     = ST_INIT;
              issue_en_s  = 1'b1;
              issue_cmd_s = init_entry(2'd0);
              init_idx_s  = 2'd1;
            end else begin
              init_idx_s = 2'd0;
            end
          end
          ST_INIT: begin
            if (init_idx_r == INIT_END) begin
              state_s     = ST_IDLE;
              init_done_s = 1'b1;
              init_idx_s  = 2'd0;
            end else begin
              issue_en_s  = 1'b1;
              issue_cmd_s = init_entry(init_idx_r);
              init_idx_s  = init_idx_r + 2'd1;
            end
          end
          ST_IDLE: begin
            grant_en_s = 1'b1;
          end
          ST_RD_WAIT: begin
            if (match_s) begin
              rsp_v_s[rd_idx_r] = 1'b1;
              rsp_data_s        = in_slot2[19:4];
              state_s           = ST_IDLE;
              grant_en_s        = 1'b1;
            end else if (cnt_r + CNT_W'(1) == CNT_W'(TIMEOUT_FRAMES)) begin
              rsp_v_s[rd_idx_r] = 1'b1;
              rsp_data_s        = 16'hFFFF;
              rsp_to_s          = 1'b1;
              state_s           = ST_IDLE;
              grant_en_s        = 1'b1;
            end else begin
              cnt_s = cnt_r + CNT_W'(1);
            end
          end
          default: begin
            state_s = ST_WAIT_RDY;
          end
        endcase
        // grant may follow a read completion in the same strobe
        if (grant_en_s && grant_any_s) begin
          ack_s            = grant_s;
          issue_en_s       = 1'b1;
          issue_cmd_s.rd   = req_rd[gidx_s];
          issue_cmd_s.addr = addr_arr_s[gidx_s];
          issue_cmd_s.data = wdata_arr_s[gidx_s];
          if (gidx_s == IDX_W'(NREQ - 1)) begin
            ptr_s = '0;
          end else begin
            ptr_s = gidx_s + IDX_W'(1);
          end
          if (req_rd[gidx_s]) begin
            state_s   = ST_RD_WAIT;
            rd_idx_s  = gidx_s;
            rd_addr_s = addr_arr_s[gidx_s];
            cnt_s     = '0;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          ptr_s = ptr_r;
        end
      end
      if (issue_en_s) begin
        slot1_s   = slot1_of(issue_cmd_s);
        slot1_v_s = 1'b1;
        slot2_s   = slot2_of(issue_cmd_s);
        slot2_v_s = ~issue_cmd_s.rd;
      end else begin
        slot1_v_s = 1'b0;
      end
    end else begin
      state_s = state_r;
    end
  end

  // state and registered outputs
  always_ff @(posedge ac97_bitclk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_WAIT_RDY;
      ptr_r       <= '0;
      init_idx_r  <= 2'd0;
      rd_idx_r    <= '0;
      rd_addr_r   <= 7'h00;
      cnt_r       <= '0;
      slot1_r     <= 20'h00000;
      slot1_v_r   <= 1'b0;
      slot2_r     <= 20'h00000;
      slot2_v_r   <= 1'b0;
      ack_r       <= '0;
      rsp_v_r     <= '0;
      rsp_data_r  <= 16'h0000;
      rsp_to_r    <= 1'b0;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      init_idx_r  <= init_idx_s;
      rd_idx_r    <= rd_idx_s;
      rd_addr_r   <= rd_addr_s;
      cnt_r       <= cnt_s;
      slot1_r     <= slot1_s;
      slot1_v_r   <= slot1_v_s;
      slot2_r     <= slot2_s;
      slot2_v_r   <= slot2_v_s;
      ack_r       <= ack_s;
      rsp_v_r     <= rsp_v_s;
      rsp_data_r  <= rsp_data_s;
      rsp_to_r    <= rsp_to_s;
      init_done_r <= init_done_s;
    end
  end

  assign req_ack              = ack_r;
  assign rsp_valid            = rsp_v_r;
  assign rsp_data             = rsp_data_r;
  assign rsp_timeout          = rsp_to_r;
  assign init_done            = init_done_r;
  assign ac97_out_slot1       = slot1_r;
  assign ac97_out_slot1_valid = slot1_v_r;
  assign ac97_out_slot2       = slot2_r;
  assign ac97_out_slot2_valid = slot2_v_r;

endmodule
